vote_packet_processor: RTL and testbench
========================================

# vote_packet_processor

Parametrised successor to the single-byte vote processor. It parses framed vote packets from the UART byte stream: header, multi-byte voter ID, candidate index and XOR checksum. Each packet is checked for length, range, checksum and inter-byte timeout. A saturating per-candidate tally bank is kept and can be read by index. It sits between `uart_receive` and the encryption/RNG path in `top_level`.

## Interface
Parameters:
- `NUM_CANDIDATES`, 4: number of valid candidates, ≥2; `CW = $clog2(NUM_CANDIDATES)`.
- `VOTER_ID_BYTES`, 2: voter ID length in bytes, ≥1.
- `TALLY_WIDTH`, 16: width of each tally counter.
- `TIMEOUT_CYCLES`, 1_000_000: maximum clk_in cycles allowed between bytes inside a packet.

Ports:
- `clk_in` in 1: single clock.
- `rst_in` in 1: reset, asynchronous, active-low.
- `valid_in` in 1: one-cycle strobe; `new_byte_in` is valid.
- `new_byte_in` in 8: received byte.
- `clear_tally_in` in 1: synchronous clear of all tallies.
- `tally_sel_in` in CW: tally index to read.
- `tally_out` out TALLY_WIDTH: registered tally of `tally_sel_in`.
- `vote_out` out CW: candidate of the last accepted vote.
- `voter_id_out` out 8*VOTER_ID_BYTES: voter ID of the last accepted vote, first byte in the MSBs.
- `valid_vote_out` out 1: one-cycle pulse; vote accepted.
- `error_out` out 1: one-cycle pulse; packet rejected.
- `error_code_out` out 2: 1 = BAD_CAND, 2 = BAD_CSUM, 3 = TIMEOUT; holds last value.

## Operation
- Packet format: `0xA5`, then ID[0..VOTER_ID_BYTES-1], then CAND, then CSUM. CSUM is the XOR of all ID bytes and CAND (header excluded).
- States: IDLE, ID, CAND, CSUM.
  - IDLE: a byte equal to `0xA5` → ID; the running XOR and byte counter clear. Any other byte is dropped silently.
  - ID: each byte shifts into the ID register and is XORed into the running checksum. After VOTER_ID_BYTES bytes → CAND.
  - CAND: latch the byte and XOR it in → CSUM.
  - CSUM: on a byte → IDLE, with exactly one of these outcomes, checked in priority order:
    - CAND ≥ NUM_CANDIDATES → error BAD_CAND.
    - Byte ≠ running XOR → error BAD_CSUM.
    - Otherwise accept.
- `0xA5` inside a packet is ordinary data. There is no resync.
- Timeout: a counter runs in every non-IDLE state and resets on each `valid_in`. When it reaches TIMEOUT_CYCLES-1 with no byte that cycle, the FSM goes to IDLE and flags error TIMEOUT.
- Accept:
  - `vote_out` and `voter_id_out` update.
  - `valid_vote_out` pulses.
  - `tally[CAND]` increments, saturating at 2^TALLY_WIDTH-1.
- Rejected packets change no tally, `vote_out` or `voter_id_out`.
- `clear_tally_in` zeroes all tallies. If it coincides with an accept, the clear wins: the tally stays 0, but `valid_vote_out` still pulses.
- `tally_sel_in` ≥ NUM_CANDIDATES reads 0.

## Timing
- Reset (rst_in=0, async): all outputs 0, all tallies 0, FSM in IDLE, timeout counter 0. Reset mid-packet discards the packet with no error pulse.
- `valid_vote_out` / `error_out` assert the cycle after the CSUM byte's `valid_in` (latency 1), for exactly 1 cycle.
- The tally increment is visible on `tally_out` 2 cycles after the CSUM `valid_in`:
  - 1 cycle to update the tally register;
  - 1 cycle for the registered read.
- `tally_out` latency from `tally_sel_in` is 1 cycle.
- Back-to-back `valid_in` on consecutive cycles is supported. A header may arrive the cycle after CSUM; the FSM is already in IDLE.
- A byte arriving on the timeout cycle wins: no timeout, and the byte is processed.
- The timeout error pulse comes 1 cycle after the counter reaches its limit.

## Structure
- Package `vote_pkg`:
  - `HEADER_BYTE = 8'hA5`;
  - `vote_state_t` enum {IDLE, ID, CAND, CSUM};
  - `vote_err_t` enum {ERR_NONE = 0, ERR_BAD_CAND, ERR_BAD_CSUM, ERR_TIMEOUT}.
- Sub-module `vote_tally_bank`, parametrised by NUM_CANDIDATES and TALLY_WIDTH. It holds the saturating increment, clear-priority logic and registered read port.
- Parser FSM, ID shift register, XOR and timeout counter stay in `vote_packet_processor`.

## Test plan
Defaults apply unless stated.
1. Good packet: A5 12 34 02 24 → cycle+1: `valid_vote_out`=1, `vote_out`=2, `voter_id_out`=0x1234; `tally[2]`=1 two cycles after the last byte.
2. Bad checksum: A5 12 34 02 25 → `error_out`=1, `error_code_out`=2; all tallies unchanged.
3. Bad candidate: A5 12 34 07 21 → `error_code_out`=1 (BAD_CAND wins over the checksum check).
4. Timeout (TIMEOUT_CYCLES=16): A5 12, then idle → `error_code_out`=3 at the 17th cycle after `12`. A following A5 12 34 01 27 is accepted with `vote_out`=1.
5. Saturation and clear (TALLY_WIDTH=2): 4 valid votes for candidate 0 → `tally_out`=3. `clear_tally_in` coincident with a 5th vote → `tally_out`=0 and `valid_vote_out`=1.
6. Async reset mid-packet after A5 12 → all outputs 0 immediately. After release, A5 00 00 03 03 → accepted, `vote_out`=3.

Source files
------------

// File: rtl/vote_pkg.sv
// ---------------------------------------------------------------------------
// vote_pkg
// Shared definitions for the vote packet processor: the packet header byte,
// the parser state encoding, the error codes reported on error_code_out and
// a small helper that folds one byte into the running XOR checksum.
// ---------------------------------------------------------------------------
package vote_pkg;

  localparam logic [7:0] HEADER_BYTE = 8'hA5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ID   = 2'd1,
    CAND = 2'd2,
    CSUM = 2'd3
  } vote_state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_BAD_CAND = 2'd1,
    ERR_BAD_CSUM = 2'd2,
    ERR_TIMEOUT  = 2'd3
  } vote_err_t;

  // Fold one received byte into the running checksum.
  function automatic logic [7:0] csum_fold(input logic [7:0] acc, input logic [7:0] data);
    return acc ^ data;
  endfunction

endpackage

// File: rtl/vote_tally_bank.sv
// ---------------------------------------------------------------------------
// vote_tally_bank
// Bank of saturating per-candidate vote counters with a synchronous clear
// and one registered read port.
//   clk_in      : clock
//   rst_in      : asynchronous active-low reset (all tallies and read to 0)
//   clear_in    : zero every tally; takes priority over a same-cycle increment
//   inc_in      : increment the tally selected by inc_idx_in
//   inc_idx_in  : candidate to increment
//   sel_in      : candidate to read
//   tally_out   : registered tally of sel_in (0 for an out-of-range index)
// ---------------------------------------------------------------------------
module vote_tally_bank #(
  parameter int NUM_CANDIDATES = 4,
  parameter int TALLY_WIDTH    = 16,
  localparam int CW = (NUM_CANDIDATES > 1) ? $clog2(NUM_CANDIDATES) : 1
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   clear_in,
  input  logic                   inc_in,
  input  logic [CW-1:0]          inc_idx_in,
  input  logic [CW-1:0]          sel_in,
  output logic [TALLY_WIDTH-1:0] tally_out
);

  logic [TALLY_WIDTH-1:0] tally_q [NUM_CANDIDATES];
  logic [TALLY_WIDTH-1:0] tally_d [NUM_CANDIDATES];
  logic [TALLY_WIDTH-1:0] rd_q;
  logic [TALLY_WIDTH-1:0] rd_d;

  // Next tally values: clear beats increment, increment saturates at all-ones.
  always_comb begin
    tally_d = tally_q;
    if (clear_in) begin
      for (int i = 0; i < NUM_CANDIDATES; i++) begin
        tally_d[i] = '0;
      end
    end else if (inc_in && (int'(inc_idx_in) < NUM_CANDIDATES)) begin
      if (tally_q[inc_idx_in] != {TALLY_WIDTH{1'b1}}) begin
        tally_d[inc_idx_in] = tally_q[inc_idx_in] + TALLY_WIDTH'(1);
      end else begin
        tally_d[inc_idx_in] = tally_q[inc_idx_in];
      end
    end else begin
      tally_d = tally_q;
    end
  end

  // Read mux; indices beyond the candidate count read as zero.
  always_comb begin
    rd_d = '0;
    if (int'(sel_in) < NUM_CANDIDATES) begin
      rd_d = tally_q[sel_in];
    end else begin
      rd_d = '0;
    end
  end

  // Tally storage and registered read port.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < NUM_CANDIDATES; i++) begin
        tally_q[i] <= '0;
      end
      rd_q <= '0;
    end else begin
      tally_q <= tally_d;
      rd_q    <= rd_d;
    end
  end

  assign tally_out = rd_q;

endmodule

// File: rtl/vote_packet_processor.sv
// ---------------------------------------------------------------------------
// vote_packet_processor
// Parses framed vote packets (A5, voter ID bytes, candidate, XOR checksum)
// from a UART byte stream, validates them and keeps per-candidate tallies.
//   clk_in / rst_in  : clock, asynchronous active-low reset
//   valid_in         : new_byte_in carries a received byte this cycle
//   new_byte_in      : received byte
//   clear_tally_in   : zero all tallies
//   tally_sel_in     : tally index to read
//   tally_out        : registered tally of tally_sel_in
//   vote_out         : candidate of the last accepted vote
//   voter_id_out     : voter ID of the last accepted vote, first byte in MSBs
//   valid_vote_out   : one-cycle pulse, vote accepted
//   error_out        : one-cycle pulse, packet rejected
//   error_code_out   : reason of the last rejection (holds)
// ---------------------------------------------------------------------------
module vote_packet_processor
  import vote_pkg::*;
#(
  parameter int NUM_CANDIDATES = 4,
  parameter int VOTER_ID_BYTES = 2,
  parameter int TALLY_WIDTH    = 16,
  parameter int TIMEOUT_CYCLES = 1_000_000,
  localparam int CW  = (NUM_CANDIDATES > 1) ? $clog2(NUM_CANDIDATES) : 1,
  localparam int IDW = 8 * VOTER_ID_BYTES
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   valid_in,
  input  logic [7:0]             new_byte_in,
  input  logic                   clear_tally_in,
  input  logic [CW-1:0]          tally_sel_in,
  output logic [TALLY_WIDTH-1:0] tally_out,
  output logic [CW-1:0]          vote_out,
  output logic [IDW-1:0]         voter_id_out,
  output logic                   valid_vote_out,
  output logic                   error_out,
  output logic [1:0]             error_code_out
);

  localparam int BCW = $clog2(VOTER_ID_BYTES + 1);
  localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);

  vote_state_t    state_q, state_d;
  logic [IDW-1:0] id_q, id_d;
  logic [7:0]     cand_q, cand_d;
  logic [7:0]     csum_q, csum_d;
  logic [BCW-1:0] bcnt_q, bcnt_d;
  logic [TOW-1:0] tmo_q, tmo_d;
  logic [CW-1:0]  vote_q, vote_d;
  logic [IDW-1:0] vid_q, vid_d;
  logic           vv_q, vv_d;
  logic           err_q, err_d;
  vote_err_t      code_q, code_d;
  logic           accept_s;
  logic           timeout_s;

  // A silent cycle at the limit aborts the packet; a byte in that cycle wins.
  assign timeout_s = (state_q != IDLE) && !valid_in && (tmo_q == TOW'(TIMEOUT_CYCLES - 1));

  // Parser next state, checksum/ID accumulation, outcome and timeout counter.
  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    cand_d   = cand_q;
    csum_d   = csum_q;
    bcnt_d   = bcnt_q;
    vote_d   = vote_q;
    vid_d    = vid_q;
    vv_d     = 1'b0;
    err_d    = 1'b0;
    code_d   = code_q;
    accept_s = 1'b0;

    if ((state_q == IDLE) || valid_in || timeout_s) begin
      tmo_d = '0;
    end else begin
      tmo_d = tmo_q + TOW'(1);
    end

    case (state_q)
      IDLE: begin
        if (valid_in && (new_byte_in == HEADER_BYTE)) begin
          state_d = ID;
          csum_d  = 8'h00;
          bcnt_d  = '0;
        end else begin
          state_d = IDLE;
        end
      end
      ID: begin
        if (valid_in) begin
          id_d   = IDW'({id_q, new_byte_in});
          csum_d = csum_fold(csum_q, new_byte_in);
          if (bcnt_q == BCW'(VOTER_ID_BYTES - 1)) begin
            state_d = CAND;
            bcnt_d  = '0;
          end else begin
            bcnt_d = bcnt_q + BCW'(1);
          end
        end else begin
          state_d = ID;
        end
      end
      CAND: begin
        if (valid_in) begin
          cand_d  = new_byte_in;
          csum_d  = csum_fold(csum_q, new_byte_in);
          state_d = CSUM;
        end else begin
          state_d = CAND;
        end
      end
      CSUM: begin
        if (valid_in) begin
          state_d = IDLE;
          if (int'(cand_q) >= NUM_CANDIDATES) begin
            err_d  = 1'b1;
            code_d = ERR_BAD_CAND;
          end else if (new_byte_in != csum_q) begin
            err_d  = 1'b1;
            code_d = ERR_BAD_CSUM;
          end else begin
            accept_s = 1'b1;
            vv_d     = 1'b1;
            vote_d   = cand_q[CW-1:0];
            vid_d    = id_q;
          end
        end else begin
          state_d = CSUM;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Timeout only fires on byte-less cycles, so it never collides with the case actions.
    if (timeout_s) begin
      state_d = IDLE;
      err_d   = 1'b1;
      code_d  = ERR_TIMEOUT;
    end else begin
      err_d = err_d;
    end
  end

  // Parser and output registers.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
      id_q    <= '0;
      cand_q  <= 8'h00;
      csum_q  <= 8'h00;
      bcnt_q  <= '0;
      tmo_q   <= '0;
      vote_q  <= '0;
      vid_q   <= '0;
      vv_q    <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      cand_q  <= cand_d;
      csum_q  <= csum_d;
      bcnt_q  <= bcnt_d;
      tmo_q   <= tmo_d;
      vote_q  <= vote_d;
      vid_q   <= vid_d;
      vv_q    <= vv_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  // The increment is driven in the accept cycle so the bank updates alongside valid_vote_out.
  vote_tally_bank #(
    .NUM_CANDIDATES (NUM_CANDIDATES),
    .TALLY_WIDTH    (TALLY_WIDTH)
  ) u_tally_bank (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .clear_in   (clear_tally_in),
    .inc_in     (accept_s),
    .inc_idx_in (cand_q[CW-1:0]),
    .sel_in     (tally_sel_in),
    .tally_out  (tally_out)
  );

  assign vote_out       = vote_q;
  assign voter_id_out   = vid_q;
  assign valid_vote_out = vv_q;
  assign error_out      = err_q;
  assign error_code_out = code_q;

endmodule

// File: tb/tb_vote_packet_processor.sv
// ---------------------------------------------------------------------------
// tb_vote_packet_processor
// Directed and randomized stimulus for vote_packet_processor, compared every
// cycle against a packet-level reference model (byte queue, silence counter,
// tally array).
// ---------------------------------------------------------------------------
module tb_vote_packet_processor;

  localparam int NC  = 4;
  localparam int IDB = 2;
  localparam int TW  = 2;
  localparam int TO  = 16;
  localparam int TMAX = (1 << TW) - 1;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          valid_in;
  logic [7:0]    new_byte_in;
  logic          clear_tally_in;
  logic [1:0]    tally_sel_in;
  logic [TW-1:0] tally_out;
  logic [1:0]    vote_out;
  logic [15:0]   voter_id_out;
  logic          valid_vote_out;
  logic          error_out;
  logic [1:0]    error_code_out;

  vote_packet_processor #(
    .NUM_CANDIDATES (NC),
    .VOTER_ID_BYTES (IDB),
    .TALLY_WIDTH    (TW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .valid_in       (valid_in),
    .new_byte_in    (new_byte_in),
    .clear_tally_in (clear_tally_in),
    .tally_sel_in   (tally_sel_in),
    .tally_out      (tally_out),
    .vote_out       (vote_out),
    .voter_id_out   (voter_id_out),
    .valid_vote_out (valid_vote_out),
    .error_out      (error_out),
    .error_code_out (error_code_out)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] pkt[$];
  int         idle_cnt;
  int         tally_m [NC];
  int         e_tout, e_vote, e_id, e_code;
  bit         e_vv, e_err;
  int         sel_v;
  bit         rand_sel;

  task automatic model_reset();
    pkt.delete();
    idle_cnt = 0;
    for (int i = 0; i < NC; i++) tally_m[i] = 0;
    e_tout = 0; e_vote = 0; e_id = 0; e_code = 0; e_vv = 0; e_err = 0;
  endtask

  task automatic model_step(input bit v, input logic [7:0] b, input bit clr, input int sel);
    int acc_idx;
    int cs;
    int cand;
    acc_idx = -1;
    e_vv  = 0;
    e_err = 0;
    e_tout = (sel < NC) ? tally_m[sel] : 0;
    if (v) begin
      idle_cnt = 0;
      if (pkt.size() == 0) begin
        if (b == 8'hA5) pkt.push_back(b);
      end else begin
        pkt.push_back(b);
        if (pkt.size() == IDB + 3) begin
          cs = 0;
          for (int i = 1; i <= IDB + 1; i++) cs = cs ^ int'(pkt[i]);
          cand = int'(pkt[IDB + 1]);
          if (cand >= NC) begin
            e_err = 1; e_code = 1;
          end else if (int'(b) != cs) begin
            e_err = 1; e_code = 2;
          end else begin
            e_vv = 1;
            e_vote = cand;
            e_id = 0;
            for (int i = 1; i <= IDB; i++) e_id = (e_id << 8) | int'(pkt[i]);
            acc_idx = cand;
          end
          pkt.delete();
        end
      end
    end else if (pkt.size() != 0) begin
      idle_cnt++;
      if (idle_cnt == TO) begin
        e_err = 1; e_code = 3;
        pkt.delete();
        idle_cnt = 0;
      end
    end
    if (clr) begin
      for (int i = 0; i < NC; i++) tally_m[i] = 0;
    end else if (acc_idx >= 0 && tally_m[acc_idx] < TMAX) begin
      tally_m[acc_idx]++;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic step(input bit v, input logic [7:0] b, input bit clr);
    if (rand_sel) sel_v = $urandom_range(0, NC - 1);
    valid_in       = v;
    new_byte_in    = b;
    clear_tally_in = clr;
    tally_sel_in   = 2'(sel_v);
    model_step(v, b, clr, sel_v);
    @(posedge clk_in);
    #1;
    check("valid_vote", 32'(valid_vote_out), 32'(e_vv));
    check("error", 32'(error_out), 32'(e_err));
    check("error_code", 32'(error_code_out), 32'(e_code));
    check("vote", 32'(vote_out), 32'(e_vote));
    check("voter_id", 32'(voter_id_out), 32'(e_id));
    check("tally", 32'(tally_out), 32'(e_tout));
  endtask

  task automatic send5(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                       input logic [7:0] b3, input logic [7:0] b4, input bit clr_last);
    step(1'b1, b0, 1'b0);
    step(1'b1, b1, 1'b0);
    step(1'b1, b2, 1'b0);
    step(1'b1, b3, 1'b0);
    step(1'b1, b4, clr_last);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_vote"}, 32'(vote_out), 32'd0);
    check({tag, "_id"}, 32'(voter_id_out), 32'd0);
    check({tag, "_vv"}, 32'(valid_vote_out), 32'd0);
    check({tag, "_err"}, 32'(error_out), 32'd0);
    check({tag, "_code"}, 32'(error_code_out), 32'd0);
    check({tag, "_tally"}, 32'(tally_out), 32'd0);
  endtask

  initial begin
    int k_hit;
    rst_in = 1'b0;
    valid_in = 1'b0;
    new_byte_in = 8'h00;
    clear_tally_in = 1'b0;
    tally_sel_in = 2'd0;
    sel_v = 0;
    rand_sel = 0;
    model_reset();
    #12;
    check_all_zero("reset");
    #5 rst_in = 1'b1;

    // Good packet
    sel_v = 2;
    send5(8'hA5, 8'h12, 8'h34, 8'h02, 8'h24, 1'b0);
    check("t1_vv", 32'(valid_vote_out), 32'd1);
    check("t1_vote", 32'(vote_out), 32'd2);
    check("t1_id", 32'(voter_id_out), 32'h1234);
    step(1'b0, 8'h00, 1'b0);
    check("t1_tally", 32'(tally_out), 32'd1);

    // Bad checksum, then bad candidate with a correct checksum
    send5(8'hA5, 8'h12, 8'h34, 8'h02, 8'h25, 1'b0);
    check("t2_err", 32'(error_out), 32'd1);
    check("t2_code", 32'(error_code_out), 32'd2);
    send5(8'hA5, 8'h12, 8'h34, 8'h07, 8'h21, 1'b0);
    check("t3_code", 32'(error_code_out), 32'd1);
    step(1'b0, 8'h00, 1'b0);
    check("t3_tally", 32'(tally_out), 32'd1);

    // Timeout after A5 12
    step(1'b1, 8'hA5, 1'b0);
    step(1'b1, 8'h12, 1'b0);
    k_hit = -1;
    for (int k = 1; k <= 40 && k_hit < 0; k++) begin
      step(1'b0, 8'h00, 1'b0);
      if (error_out === 1'b1) k_hit = k;
    end
    check("t4_latency", 32'(k_hit), 32'd16);
    check("t4_code", 32'(error_code_out), 32'd3);
    send5(8'hA5, 8'h12, 8'h34, 8'h01, 8'h27, 1'b0);
    check("t4_vote", 32'(vote_out), 32'd1);

    // Saturation, then clear coinciding with an accept
    sel_v = 0;
    for (int i = 0; i < 4; i++) send5(8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    check("t5_sat", 32'(tally_out), 32'd3);
    send5(8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
    check("t5_vv", 32'(valid_vote_out), 32'd1);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    check("t5_clear", 32'(tally_out), 32'd0);

    // Async reset mid-packet
    sel_v = 3;
    send5(8'hA5, 8'hBE, 8'hEF, 8'h03, 8'h52, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'hA5, 1'b0);
    step(1'b1, 8'h12, 1'b0);
    #3 rst_in = 1'b0;
    #1;
    check_all_zero("async_rst");
    model_reset();
    #2 rst_in = 1'b1;
    send5(8'hA5, 8'h00, 8'h00, 8'h03, 8'h03, 1'b0);
    check("t6_vote", 32'(vote_out), 32'd3);
    check("t6_vv", 32'(valid_vote_out), 32'd1);

    // Randomized packets with noise, gaps, corruption and clears
    rand_sel = 1;
    for (int p = 0; p < 300; p++) begin
      logic [7:0] bytes [IDB + 3];
      logic [7:0] cs;
      logic [7:0] nb;
      int noise;
      int gap;
      int r;
      noise = $urandom_range(0, 2);
      for (int n = 0; n < noise; n++) begin
        nb = 8'($urandom);
        if (nb == 8'hA5) nb = 8'h5A;
        step(1'b1, nb, ($urandom_range(0, 29) == 0));
      end
      bytes[0] = 8'hA5;
      cs = 8'h00;
      for (int i = 1; i <= IDB; i++) begin
        bytes[i] = 8'($urandom);
        cs = cs ^ bytes[i];
      end
      if ($urandom_range(0, 7) < 6) bytes[IDB + 1] = 8'($urandom_range(0, NC - 1));
      else bytes[IDB + 1] = 8'($urandom_range(NC, 255));
      cs = cs ^ bytes[IDB + 1];
      if ($urandom_range(0, 3) == 0) cs = cs ^ 8'($urandom_range(1, 255));
      bytes[IDB + 2] = cs;
      for (int i = 0; i < IDB + 3; i++) begin
        r = $urandom_range(0, 19);
        if (r < 12) gap = 0;
        else if (r < 16) gap = $urandom_range(1, 3);
        else if (r == 16) gap = TO - 2;
        else if (r == 17) gap = TO - 1;
        else if (r == 18) gap = TO;
        else gap = TO + 4;
        for (int g = 0; g < gap; g++) step(1'b0, 8'h00, ($urandom_range(0, 29) == 0));
        step(1'b1, bytes[i], ($urandom_range(0, 29) == 0));
      end
    end
    rand_sel = 0;
    step(1'b0, 8'h00, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
